// File: rtl/io_event_controller_if.sv
`default_nettype none
// ============================================================================
//  Module   : io_event_controller_if
//  Brief    : Peripheral-bus bundle between the core and the input-event
//             controller (register access plus interrupt line).
//  Revision : 1.0 - initial release
// ============================================================================
interface io_event_controller_if;
    logic [1:0]  addr_i;
    logic        we_i;
    logic [31:0] wdata_i;
    logic [31:0] rdata_o;
    logic        irq_o;

    modport master (
        output addr_i,
        output we_i,
        output wdata_i,
        input  rdata_o,
        input  irq_o
    );

    modport slave (
        input  addr_i,
        input  we_i,
        input  wdata_i,
        output rdata_o,
        output irq_o
    );
endinterface
`default_nettype wire

// File: rtl/io_event_controller.sv
`default_nettype none
// ============================================================================
//  Module   : io_event_controller
//  Brief    : Button/switch synchroniser, debouncer and latched-event
//             interrupt controller with a 4-register bus map.
//  Revision : 1.0 - initial release
// ============================================================================
module io_event_controller #(
    parameter int N_BTN           = 4,
    parameter int N_SW            = 16,
    parameter int DEBOUNCE_CYCLES = 100000
) (
    input  wire logic             clk_i,
    input  wire logic             reset_i,
    input  wire logic [N_BTN-1:0] botones_i,
    input  wire logic [N_SW-1:0]  switches_i,
    io_event_controller_if.slave  bus
);

    localparam int              c_cnt_w     = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEBOUNCE_CYCLES - 1);
    localparam logic [31:0]     c_impl_mask = 32'h0001_0000 | ((32'h1 << N_BTN) - 32'h1);

    localparam logic [1:0] c_addr_data  = 2'd0;
    localparam logic [1:0] c_addr_pend  = 2'd1;
    localparam logic [1:0] c_addr_mask  = 2'd2;
    localparam logic [1:0] c_addr_event = 2'd3;

    typedef enum logic [0:0] {
        ST_STABLE   = 1'b0,
        ST_COUNTING = 1'b1
    } db_state_t;

    logic [N_BTN-1:0] r_btn_s1, r_btn_s2;
    logic [N_SW-1:0]  r_sw_s1, r_sw_s2, r_sw_prev;
    logic [N_BTN-1:0] w_db;
    logic [N_BTN-1:0] w_rise;
    logic [31:0]      r_pend, r_mask;
    logic             r_irq;
    logic [31:0]      w_set, w_clr, w_active, w_data, w_event, w_rdata;

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            r_btn_s1  <= '0;
            r_btn_s2  <= '0;
            r_sw_s1   <= '0;
            r_sw_s2   <= '0;
            r_sw_prev <= '0;
        end else begin
            r_btn_s1  <= botones_i;
            r_btn_s2  <= r_btn_s1;
            r_sw_s1   <= switches_i;
            r_sw_s2   <= r_sw_s1;
            r_sw_prev <= r_sw_s2;
        end
    end

    for (genvar gi = 0; gi < N_BTN; gi++) begin : g_btn
        db_state_t          r_state, w_state_nxt;
        logic [c_cnt_w-1:0] r_cnt, w_cnt_nxt;
        logic               r_db, w_db_nxt;

        always_comb begin
            w_state_nxt = r_state;
            w_cnt_nxt   = r_cnt;
            w_db_nxt    = r_db;
            case (r_state)
                ST_STABLE: begin
                    if (r_btn_s2[gi] != r_db) begin
                        w_state_nxt = ST_COUNTING;
                        w_cnt_nxt   = c_cnt_w'(1);
                    end else begin
                        w_cnt_nxt   = '0;
                    end
                end
                ST_COUNTING: begin
                    // A single matching sample aborts the count: glitch rejected.
                    if (r_btn_s2[gi] == r_db) begin
                        w_state_nxt = ST_STABLE;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt == c_cnt_last) begin
                        w_db_nxt    = r_btn_s2[gi];
                        w_state_nxt = ST_STABLE;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt   = r_cnt + c_cnt_w'(1);
                    end
                end
                default: begin
                    w_state_nxt = ST_STABLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end

        always_ff @(posedge clk_i) begin
            if (!reset_i) begin
                r_state <= ST_STABLE;
                r_cnt   <= '0;
                r_db    <= 1'b0;
            end else begin
                r_state <= w_state_nxt;
                r_cnt   <= w_cnt_nxt;
                r_db    <= w_db_nxt;
            end
        end

        assign w_db[gi]   = r_db;
        assign w_rise[gi] = w_db_nxt & ~r_db;
    end

    always_comb begin
        w_set               = '0;
        w_set[N_BTN-1:0]    = w_rise;
        w_set[16]           = (r_sw_s2 != r_sw_prev);
        w_clr               = (bus.we_i && bus.addr_i == c_addr_pend) ? (bus.wdata_i & c_impl_mask) : '0;
        w_active            = r_pend & r_mask;
        w_data              = '0;
        w_data[N_SW-1:0]    = r_sw_s2;
        w_data[16 +: N_BTN] = w_db;
    end

    // Lowest-index pending bit wins; the scan runs downward so the last hit is the lowest.
    always_comb begin
        w_event = '0;
        for (int k = 31; k >= 0; k--) begin
            if (w_active[k]) begin
                w_event     = '0;
                w_event[31] = 1'b1;
                w_event[4:0] = 5'(k);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            r_pend <= '0;
            r_mask <= '0;
            r_irq  <= 1'b0;
        end else begin
            r_pend <= ((r_pend & ~w_clr) | w_set) & c_impl_mask;
            if (bus.we_i && bus.addr_i == c_addr_mask) begin
                r_mask <= bus.wdata_i & c_impl_mask;
            end
            r_irq  <= |w_active;
        end
    end

    always_comb begin
        w_rdata = '0;
        case (bus.addr_i)
            c_addr_data:  w_rdata = w_data;
            c_addr_pend:  w_rdata = r_pend;
            c_addr_mask:  w_rdata = r_mask;
            c_addr_event: w_rdata = w_event;
            default:      w_rdata = '0;
        endcase
    end

    assign bus.rdata_o = w_rdata;
    assign bus.irq_o   = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_io_event_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_io_event_controller
//  Brief    : Directed, table-driven bench for io_event_controller
//             (DEBOUNCE_CYCLES=4, N_BTN=4, N_SW=16).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_io_event_controller;

    localparam logic [1:0] c_data  = 2'd0;
    localparam logic [1:0] c_pend  = 2'd1;
    localparam logic [1:0] c_mask  = 2'd2;
    localparam logic [1:0] c_event = 2'd3;

    logic        clk = 1'b0;
    logic        reset_i;
    logic [3:0]  botones_i;
    logic [15:0] switches_i;

    io_event_controller_if bus_if ();

    io_event_controller #(
        .N_BTN           (4),
        .N_SW            (16),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk_i      (clk),
        .reset_i    (reset_i),
        .botones_i  (botones_i),
        .switches_i (switches_i),
        .bus        (bus_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_irq;
    } vec_t;

    vec_t vecs [16];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        bus_if.addr_i  = a;
        bus_if.wdata_i = d;
        bus_if.we_i    = 1'b1;
        tick();
        bus_if.we_i    = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        bus_if.addr_i = a;
        #1;
        d = bus_if.rdata_o;
    endtask

    logic [31:0] v;

    initial begin
        // Register-access table applied after reset with all inputs held high.
        vecs[0]  = '{1'b0, c_pend,  32'h0,        32'h0001000F, 1'b0};
        vecs[1]  = '{1'b1, c_mask,  32'hFFFFFFFF, 32'h0001000F, 1'b0};
        vecs[2]  = '{1'b0, c_event, 32'h0,        32'h80000000, 1'b1};
        vecs[3]  = '{1'b1, c_pend,  32'h00000001, 32'h0001000E, 1'b1};
        vecs[4]  = '{1'b0, c_event, 32'h0,        32'h80000001, 1'b1};
        vecs[5]  = '{1'b1, c_data,  32'h0,        32'h000FFFFF, 1'b1};
        vecs[6]  = '{1'b1, c_event, 32'h0,        32'h80000001, 1'b1};
        vecs[7]  = '{1'b1, c_mask,  32'h00010000, 32'h00010000, 1'b1};
        vecs[8]  = '{1'b0, c_event, 32'h0,        32'h80000010, 1'b1};
        vecs[9]  = '{1'b1, c_pend,  32'h00010000, 32'h0000000E, 1'b1};
        vecs[10] = '{1'b0, c_event, 32'h0,        32'h00000000, 1'b0};
        vecs[11] = '{1'b1, c_mask,  32'h0000000C, 32'h0000000C, 1'b0};
        vecs[12] = '{1'b0, c_event, 32'h0,        32'h80000002, 1'b1};
        vecs[13] = '{1'b1, c_pend,  32'hFFFFFFFF, 32'h00000000, 1'b1};
        vecs[14] = '{1'b0, c_pend,  32'h0,        32'h00000000, 1'b0};
        vecs[15] = '{1'b1, c_mask,  32'h0,        32'h00000000, 1'b0};

        reset_i        = 1'b0;
        botones_i      = 4'hF;
        switches_i     = 16'hFFFF;
        bus_if.addr_i  = c_data;
        bus_if.we_i    = 1'b0;
        bus_if.wdata_i = '0;

        // Reset held: every register reads zero, no interrupt.
        for (int c = 0; c < 3; c++) begin
            tick();
            for (int a = 0; a < 4; a++) begin
                rd(2'(a), v);
                chk($sformatf("reset_rd_c%0d_a%0d", c, a), v, 32'h0);
            end
            chk($sformatf("reset_irq_c%0d", c), {31'b0, bus_if.irq_o}, 32'h0);
        end
        reset_i = 1'b1;
        ticks(12);
        rd(c_data, v); chk("post_reset_data", v, 32'h000FFFFF);
        rd(c_mask, v); chk("post_reset_mask", v, 32'h0);

        for (int i = 0; i < 16; i++) begin
            bus_if.addr_i  = vecs[i].addr;
            bus_if.wdata_i = vecs[i].wdata;
            bus_if.we_i    = vecs[i].we;
            tick();
            bus_if.we_i    = 1'b0;
            chk($sformatf("vec%0d_rd", i), bus_if.rdata_o, vecs[i].exp_rd);
            chk($sformatf("vec%0d_irq", i), {31'b0, bus_if.irq_o}, {31'b0, vecs[i].exp_irq});
        end

        // Button 2 press: PEND at edge 5, irq at edge 6, W1C clears it.
        botones_i  = 4'h0;
        switches_i = 16'h0000;
        ticks(12);
        wr(c_pend, 32'hFFFFFFFF);
        rd(c_pend, v); chk("t2_pend_clear", v, 32'h0);
        wr(c_mask, 32'h4);
        botones_i = 4'h4;
        ticks(5);
        rd(c_pend, v); chk("t2_pend_edge4", v, 32'h0);
        tick();
        rd(c_pend, v); chk("t2_pend_edge5", v, 32'h4);
        chk("t2_irq_edge5", {31'b0, bus_if.irq_o}, 32'h0);
        tick();
        chk("t2_irq_edge6", {31'b0, bus_if.irq_o}, 32'h1);
        rd(c_event, v); chk("t2_event", v, 32'h80000002);
        wr(c_pend, 32'h4);
        rd(c_pend, v); chk("t2_pend_w1c", v, 32'h0);
        chk("t2_irq_w1c_edge", {31'b0, bus_if.irq_o}, 32'h1);
        tick();
        chk("t2_irq_after", {31'b0, bus_if.irq_o}, 32'h0);

        // Button 0 glitch of 3 cycles is rejected.
        botones_i = 4'h5;
        ticks(3);
        botones_i = 4'h4;
        ticks(8);
        rd(c_pend, v); chk("t3_pend", v, 32'h0);
        rd(c_data, v); chk("t3_data", v, 32'h00040000);
        chk("t3_irq", {31'b0, bus_if.irq_o}, 32'h0);

        // Switch change: PEND[16] at edge 2, irq at edge 3.
        wr(c_mask, 32'h10000);
        switches_i = 16'h0081;
        ticks(2);
        rd(c_pend, v); chk("t4_pend_edge1", v, 32'h0);
        rd(c_data, v); chk("t4_data_edge1", v, 32'h00040081);
        tick();
        rd(c_pend, v); chk("t4_pend_edge2", v, 32'h10000);
        chk("t4_irq_edge2", {31'b0, bus_if.irq_o}, 32'h0);
        tick();
        chk("t4_irq_edge3", {31'b0, bus_if.irq_o}, 32'h1);
        rd(c_event, v); chk("t4_event", v, 32'h80000010);

        // Event priority under mask, and set-wins on a colliding W1C.
        botones_i  = 4'h0;
        switches_i = 16'h0000;
        ticks(10);
        wr(c_pend, 32'hFFFFFFFF);
        botones_i  = 4'h5;
        switches_i = 16'h0003;
        ticks(10);
        rd(c_pend, v); chk("t5_pend", v, 32'h10005);
        wr(c_mask, 32'h10004);
        rd(c_event, v); chk("t5_event", v, 32'h80000002);
        botones_i = 4'h1;
        ticks(10);
        rd(c_pend, v); chk("t5_pend_release", v, 32'h10005);
        botones_i = 4'h5;
        ticks(5);
        rd(c_data, v); chk("t5_data_edge4", v, 32'h00010003);
        wr(c_pend, 32'h4);
        rd(c_pend, v); chk("t5_pend_collide", v, 32'h10005);
        rd(c_data, v); chk("t5_data_edge5", v, 32'h00050003);

        // Reset mid-debounce aborts the pending acceptance.
        botones_i  = 4'h0;
        switches_i = 16'h0000;
        ticks(10);
        wr(c_pend, 32'hFFFFFFFF);
        rd(c_pend, v); chk("t6_pend_clear", v, 32'h0);
        botones_i = 4'h2;
        ticks(4);
        reset_i = 1'b0;
        tick();
        reset_i   = 1'b1;
        botones_i = 4'h0;
        ticks(10);
        rd(c_pend, v); chk("t6_pend", v, 32'h0);
        rd(c_data, v); chk("t6_data", v, 32'h0);
        rd(c_mask, v); chk("t6_mask", v, 32'h0);
        chk("t6_irq", {31'b0, bus_if.irq_o}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
